// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// Optional parity support is selected with the UART_RX_PARITY_EN macro.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  // Two-out-of-three vote used for every bit decision.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle (1).
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  // Shift the raw line through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= 1'b1;
      ff2_q <= 1'b1;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver with majority-of-3 mid-bit sampling and a one-byte holding
// register with valid/ready handshake. Define UART_RX_PARITY_EN to expect an
// even parity bit between the data bits and the stop bit.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_VALUE = 100000,
  parameter int BAUD      = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = CLK_VALUE / BAUD;
  localparam int H   = DIV / 2;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] H_M1     = CW'(H - 1);
  localparam logic [CW-1:0] H_0      = CW'(H);
  localparam logic [CW-1:0] H_P1     = CW'(H + 1);

  // Three sample points plus a decision slot must fit inside one bit period.
  if (DIV < 6) begin : g_div_check
    $error("uart_rx_os: CLK_VALUE/BAUD must be at least 6");
  end

  logic                 line_s;
  logic                 tick_s;
  logic                 decision_s;
  logic                 par_err_s;
  logic [CW-1:0]        cnt_d;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_q;
  logic                 done_q;
  logic                 frame_err_q;
  logic                 busy_q;
  logic [7:0]           rx_data_q;
  logic                 rx_valid_q;
  logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_q;
`endif

  uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (line_s)
  );

  assign tick_s     = (cnt_q == H_P1);
  assign decision_s = maj3(samp_q[1], samp_q[0], line_s);
  assign cnt_d      = (cnt_q == CNT_MAX) ? CNT_ZERO : (cnt_q + CNT_ONE);
`ifdef UART_RX_PARITY_EN
  assign par_err_s  = par_q;
`else
  assign par_err_s  = 1'b0;
`endif

  // Frame state machine: bit timing, sampling, shifting and error detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      samp_q      <= 2'b11;
      shift_q     <= 8'h00;
      bit_q       <= 3'd0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      if (cnt_q == H_M1) samp_q[1] <= line_s;
      if (cnt_q == H_0)  samp_q[0] <= line_s;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= CNT_ZERO;
          if (!line_s) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          cnt_q <= cnt_d;
          if (tick_s) begin
            if (decision_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              cnt_q   <= CNT_ZERO;
            end else begin
              state_q <= ST_DATA;
              bit_q   <= 3'd0;
`ifdef UART_RX_PARITY_EN
              par_q   <= 1'b0;
`endif
            end
          end
        end
        ST_DATA: begin
          cnt_q <= cnt_d;
          if (tick_s) begin
            shift_q <= {decision_s, shift_q[DATA_BITS-1:1]};
            bit_q   <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_q ^ decision_s;
            if (bit_q == 3'd7) state_q <= ST_PARITY;
`else
            if (bit_q == 3'd7) state_q <= ST_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          cnt_q <= cnt_d;
          if (tick_s) begin
            par_q   <= par_q ^ decision_s;
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          cnt_q <= cnt_d;
          if (tick_s) begin
            cnt_q <= CNT_ZERO;
            if (decision_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              if (par_err_s) frame_err_q <= 1'b1;
              else           done_q      <= 1'b1;
            end else begin
              state_q     <= ST_BREAK;
              frame_err_q <= 1'b1;
            end
          end
        end
        ST_BREAK: begin
          cnt_q <= CNT_ZERO;
          if (line_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Holding register: accept a completed byte unless the previous one is still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter CLK_VALUE, default 100000, clk frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate; DIV = CLK_VALUE/BAUD (integer divide) SHALL be >= 6, else elaboration error.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx  input  1  serial line, asynchronous, idle high.
REQ-006 rx_data  output  8  received byte.
REQ-007 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: byte completed while holding register full.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx SHALL pass a 2-flop synchronizer before use; all references to "line" mean the synchronized value.
REQ-013 Frame: start(0), 8 data LSB first, [parity], stop(1).
REQ-014 States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
REQ-015 IDLE -> START when line low; bit counter cnt cleared to 0 on entry, counts 0..DIV-1 per bit, wrapping.
REQ-016 Each bit value = majority of line at cnt = H-1, H, H+1 (H = DIV/2); decision taken at cnt = H+1.
REQ-017 START decision high -> IDLE (glitch rejected, no pulses); low -> DATA.
REQ-018 DATA shifts 8 decisions LSB first, then -> PARITY or STOP.
REQ-019 STOP decision high -> IDLE immediately (no wait for cnt wrap) and byte delivered; low -> frame_err pulse, byte discarded, -> BREAK.
REQ-020 BREAK -> IDLE only after line seen high.
REQ-021 Delivery: if rx_valid=0, or rx_ready=1 the same cycle, rx_data loads and rx_valid=1 next cycle, no overrun.
REQ-022 Delivery with rx_valid=1 and rx_ready=0: new byte dropped, rx_data unchanged, overrun pulses one cycle.
REQ-023 rx_valid clears the cycle after rx_valid && rx_ready with no simultaneous delivery.
REQ-024 Latency: rx_valid rises exactly 9*DIV+H+5 clk cycles after the first clk edge sampling rx low (10*DIV+H+5 with parity).
REQ-025 Back-to-back frames with no idle gap beyond the stop decision SHALL be received without loss.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, cnt 0, synchronizer flops 1, rx_data 8'h00, rx_valid 0, frame_err 0, overrun 0, busy 0.
REQ-027 Reset mid-frame discards the partial byte; after release, reception resumes at the next falling edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state present, even parity bit expected after data; mismatch -> frame_err pulse at stop decision, byte discarded, state IDLE if stop high else BREAK.
REQ-029 Macro undefined: no parity bit, DATA -> STOP directly, no parity logic synthesized.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum, DATA_BITS=8, and the majority-of-3 function.
REQ-031 Sub-module uart_sync (2-flop synchronizer, reset value 1) SHALL be instantiated for rx.

Verification (defaults, DIV=10, H=5)
REQ-032 Frame 0xA5, rx_ready=1 -> rx_data=8'hA5, rx_valid high exactly 1 cycle, latency 100 cycles, no error pulses.
REQ-033 rx low 3 cycles then high -> state returns IDLE, no rx_valid, frame_err, or overrun.
REQ-034 Frame 0x3C with stop bit low for 20 cycles -> one frame_err pulse, no rx_valid, busy high until rx returns high.
REQ-035 Frames 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=8'h11 held, one overrun pulse; assert rx_ready -> rx_valid clears next cycle.
REQ-036 rst_n low at data bit 4 of 0x5A, released, then frame 0xC3 -> only 8'hC3 delivered.
REQ-037 With UART_RX_PARITY_EN: 0x07 with parity 1 -> accepted; parity 0 -> frame_err, no rx_valid.
